// File: rtl/vip_matrix_generate_3x3.sv
// 3x3 neighbourhood generator with internal line buffers, coordinates and a window-valid flag.
// Border handling: zero fill by default; define BORDER_REPLICATE_EN for replicate-edge mode.
module vip_matrix_generate_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HDISP  = 480,
    parameter int IMG_VDISP  = 272,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_data,
    output logic                  matrix_frame_vsync,
    output logic                  matrix_frame_href,
    output logic                  matrix_frame_clken,
    output logic                  matrix_window_valid,
    output logic [CNT_WIDTH-1:0]  matrix_col,
    output logic [CNT_WIDTH-1:0]  matrix_row,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33
);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(IMG_HDISP - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_MAX = CNT_WIDTH'(IMG_VDISP - 1);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [CNT_WIDTH-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d, pix_row;
    logic                 line_full_q, line_full_d;
    logic                 pix_accept, pix_excess, lb_write;
    logic [AW-1:0]        lb_addr;

    logic                 s1_vsync_q, s1_href_q, s1_stb_q, s1_excess_q;
    pix_t                 s1_pix_q;
    logic [CNT_WIDTH-1:0] s1_col_q, s1_row_q;

    pix_t lb0_mem [IMG_HDISP];
    pix_t lb1_mem [IMG_HDISP];
    pix_t lb0_rd_q, lb1_rd_q;

    pix_t                 new_col [3];
    pix_t                 win_q [3][3];
    pix_t                 win_d [3][3];
    logic                 vsync_q, href_q, clken_q, valid_q;
    logic [CNT_WIDTH-1:0] mcol_q, mrow_q;

    assign pix_accept = per_frame_href & per_frame_clken;
    // Pixels past the end of a full line still flow through the window but never touch the RAMs.
    assign pix_excess = pix_accept & line_full_q;
    assign lb_write   = pix_accept & ~line_full_q;
    assign pix_row    = per_frame_vsync ? '0 : row_cnt_q;
    assign lb_addr    = col_cnt_q[AW-1:0];

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        col_cnt_d   = col_cnt_q;
        line_full_d = line_full_q;
        row_cnt_d   = row_cnt_q;
        if (!per_frame_href) begin
            col_cnt_d   = '0;
            line_full_d = 1'b0;
        end else if (lb_write) begin
            if (col_cnt_q == COL_MAX) line_full_d = 1'b1;
            else                      col_cnt_d   = col_cnt_q + ONE;
        end
        if (per_frame_vsync)
            row_cnt_d = '0;
        else if (s1_href_q && !per_frame_href && row_cnt_q != ROW_MAX)
            row_cnt_d = row_cnt_q + ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            line_full_q <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_href_q   <= 1'b0;
            s1_stb_q    <= 1'b0;
            s1_excess_q <= 1'b0;
            s1_pix_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            line_full_q <= line_full_d;
            s1_vsync_q  <= per_frame_vsync;
            s1_href_q   <= per_frame_href;
            s1_stb_q    <= pix_accept;
            s1_excess_q <= pix_excess;
            if (pix_accept) begin
                s1_pix_q <= per_img_data;
                s1_col_q <= col_cnt_q;
                s1_row_q <= pix_row;
            end
        end
    end

    // NOTE: line buffers are not reset; rows are rewritten before they can reach a valid window.
    always_ff @(posedge clk) begin
        lb0_rd_q <= lb0_mem[lb_addr];
        lb1_rd_q <= lb1_mem[lb_addr];
        if (lb_write) begin
            lb0_mem[lb_addr] <= per_img_data;
            lb1_mem[lb_addr] <= lb0_mem[lb_addr];
        end
    end

    always_comb begin
        new_col[0] = lb1_rd_q;
        new_col[1] = lb0_rd_q;
        new_col[2] = s1_pix_q;
`ifdef BORDER_REPLICATE_EN
        if (s1_row_q == '0) begin
            new_col[0] = s1_pix_q;
            new_col[1] = s1_pix_q;
        end else if (s1_row_q == ONE) begin
            new_col[0] = lb0_rd_q;
        end
`else
        if (s1_row_q == '0) begin
            new_col[0] = '0;
            new_col[1] = '0;
        end else if (s1_row_q == ONE) begin
            new_col[0] = '0;
        end
`endif
    end

    always_comb begin
        win_d = win_q;
`ifndef BORDER_REPLICATE_EN
        if (!s1_href_q) win_d = '{default: '0};
`endif
        if (s1_stb_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = new_col[r];
`ifdef BORDER_REPLICATE_EN
                if (s1_col_q == '0) begin
                    win_d[r][0] = new_col[r];
                    win_d[r][1] = new_col[r];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q   <= '{default: '0};
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            valid_q <= 1'b0;
            mcol_q  <= '0;
            mrow_q  <= '0;
        end else begin
            win_q   <= win_d;
            vsync_q <= s1_vsync_q;
            href_q  <= s1_href_q;
            clken_q <= s1_stb_q;
            valid_q <= s1_stb_q & ~s1_excess_q & (s1_row_q >= TWO) & (s1_col_q >= TWO);
            if (s1_stb_q) begin
                mcol_q <= s1_col_q;
                mrow_q <= s1_row_q;
            end
        end
    end

    assign matrix_frame_vsync  = vsync_q;
    assign matrix_frame_href   = href_q;
    assign matrix_frame_clken  = clken_q;
    assign matrix_window_valid = valid_q;
    assign matrix_col          = mcol_q;
    assign matrix_row          = mrow_q;
    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];
endmodule

// File: tb/tb_vip_matrix_generate_3x3.sv
// Directed bench for vip_matrix_generate_3x3 on an 8-pixel-wide image (pixel = row*16 + col).
// Expected border values follow BORDER_REPLICATE_EN when it is defined for the build.
module tb_vip_matrix_generate_3x3;
    localparam int DW = 8;
    localparam int HD = 8;
    localparam int VD = 8;
    localparam int CW = 10;
    localparam int LOGN = 2048;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          vs = 1'b0, hr = 1'b0, ce = 1'b0;
    logic [DW-1:0] din = '0;
    logic          m_vs, m_hr, m_ce, m_valid;
    logic [CW-1:0] m_col, m_row;
    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    vip_matrix_generate_3x3 #(.DATA_WIDTH(DW), .IMG_HDISP(HD), .IMG_VDISP(VD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(din),
        .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hr), .matrix_frame_clken(m_ce),
        .matrix_window_valid(m_valid), .matrix_col(m_col), .matrix_row(m_row),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2:0]    side_log  [LOGN];
    logic [2:0]    sbo_log   [LOGN];
    logic [71:0]   win_log   [LOGN];
    logic [CW-1:0] col_log   [LOGN];
    logic [CW-1:0] row_log   [LOGN];
    logic          valid_log [LOGN];

    typedef struct {
        int          k;
        string       name;
        logic [71:0] win;
        bit          chk_win;
        logic        valid;
        logic [CW-1:0] col;
        logic [CW-1:0] row;
    } exp_t;

    function automatic logic [71:0] win9(input logic [7:0] a, b, c, d, e, f, g, h, i);
        return {a, b, c, d, e, f, g, h, i};
    endfunction

    function automatic exp_t mk(input int k, input string n, input logic [71:0] w, input bit cw,
                                input logic v, input int c, input int r);
        exp_t x;
        x.k = k; x.name = n; x.win = w; x.chk_win = cw; x.valid = v;
        x.col = CW'(c); x.row = CW'(r);
        return x;
    endfunction

    // One pixel-clock step: drive at the falling edge, log outputs at the next falling edge.
    task automatic tick(input logic v, input logic h, input logic c, input logic [7:0] d);
        if (cyc >= LOGN - 1) begin
            $display("FAIL tick_budget cycles=%0d limit=%0d", cyc, LOGN - 1);
            $fatal(1);
        end
        vs = v; hr = h; ce = c; din = d;
        side_log[cyc] = {v, h, h & c};
        @(posedge clk);
        @(negedge clk);
        sbo_log[cyc]   = {m_vs, m_hr, m_ce};
        win_log[cyc]   = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
        col_log[cyc]   = m_col;
        row_log[cyc]   = m_row;
        valid_log[cyc] = m_valid;
        cyc++;
    endtask

    task automatic frame_start();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    // Sends n pixels of value r*16+col, then two blank cycles; s is the tick of column 0.
    task automatic send_line(input int r, input int n, output int s);
        s = cyc;
        for (int i = 0; i < n; i++) tick(0, 1, 1, 8'(r * 16 + i));
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        exp_t e[$];
        int s;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_vs, m_hr, m_ce, m_valid, m_col, m_row, p11, p12, p13, p21, p22, p23, p31, p32, p33} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {m_vs, m_hr, m_ce, m_valid, m_col, m_row, p11, p12, p13, p21, p22, p23, p31, p32, p33});
        end
        rstn = 1'b1;
        tick(0, 0, 0, 0);
        send_line(5, HD, s);
        e.push_back(mk(s + 1, "post_reset_c0", 72'h0, 0, 0, 0, 0));
`ifdef BORDER_REPLICATE_EN
        e.push_back(mk(s + 2, "post_reset_c1", win9(8'h50, 8'h50, 8'h51, 8'h50, 8'h50, 8'h51, 8'h50, 8'h50, 8'h51), 1, 0, 1, 0));
`else
        e.push_back(mk(s + 2, "post_reset_c1", win9(0, 0, 0, 0, 0, 0, 0, 8'h50, 8'h51), 1, 0, 1, 0));
`endif
        foreach (e[i]) begin
            if (e[i].chk_win) begin
                checks++;
                if (win_log[e[i].k] !== e[i].win) begin failures++; $display("FAIL %s window got=%h required=%h", e[i].name, win_log[e[i].k], e[i].win); end
            end
            checks++; if (valid_log[e[i].k] !== e[i].valid) begin failures++; $display("FAIL %s valid got=%b required=%b", e[i].name, valid_log[e[i].k], e[i].valid); end
            checks++; if (col_log[e[i].k] !== e[i].col) begin failures++; $display("FAIL %s col got=%0d required=%0d", e[i].name, col_log[e[i].k], e[i].col); end
            checks++; if (row_log[e[i].k] !== e[i].row) begin failures++; $display("FAIL %s row got=%0d required=%0d", e[i].name, row_log[e[i].k], e[i].row); end
        end
    endtask

    task automatic test_ramp_frame();
        exp_t e[$];
        int s0, s1, s2, s3;
        frame_start();
        send_line(0, HD, s0);
        send_line(1, HD, s1);
        send_line(2, HD, s2);
        send_line(3, HD, s3);
        e.push_back(mk(s0 + 1, "ramp_r0c0", 72'h0, 1, 0, 0, 0));
        e.push_back(mk(s2 + 3, "ramp_r2c2", win9(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22), 1, 1, 2, 2));
        e.push_back(mk(s3 + 8, "ramp_r3c7", win9(8'h15, 8'h16, 8'h17, 8'h25, 8'h26, 8'h27, 8'h35, 8'h36, 8'h37), 1, 1, 7, 3));
`ifdef BORDER_REPLICATE_EN
        e.push_back(mk(s0 + 2, "ramp_r0c1", win9(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01), 1, 0, 1, 0));
        e.push_back(mk(s1 + 1, "ramp_r1c0", win9(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10), 1, 0, 0, 1));
        e.push_back(mk(s1 + 6, "ramp_r1c5", win9(8'h03, 8'h04, 8'h05, 8'h03, 8'h04, 8'h05, 8'h13, 8'h14, 8'h15), 1, 0, 5, 1));
        e.push_back(mk(s2 + 2, "ramp_r2c1", win9(8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11, 8'h20, 8'h20, 8'h21), 1, 0, 1, 2));
`else
        e.push_back(mk(s0 + 2, "ramp_r0c1", win9(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01), 1, 0, 1, 0));
        e.push_back(mk(s1 + 1, "ramp_r1c0", win9(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h10), 1, 0, 0, 1));
        e.push_back(mk(s1 + 6, "ramp_r1c5", win9(0, 0, 0, 8'h03, 8'h04, 8'h05, 8'h13, 8'h14, 8'h15), 1, 0, 5, 1));
        e.push_back(mk(s2 + 2, "ramp_r2c1", win9(0, 8'h00, 8'h01, 0, 8'h10, 8'h11, 0, 8'h20, 8'h21), 1, 0, 1, 2));
`endif
        foreach (e[i]) begin
            if (e[i].chk_win) begin
                checks++;
                if (win_log[e[i].k] !== e[i].win) begin failures++; $display("FAIL %s window got=%h required=%h", e[i].name, win_log[e[i].k], e[i].win); end
            end
            checks++; if (valid_log[e[i].k] !== e[i].valid) begin failures++; $display("FAIL %s valid got=%b required=%b", e[i].name, valid_log[e[i].k], e[i].valid); end
            checks++; if (col_log[e[i].k] !== e[i].col) begin failures++; $display("FAIL %s col got=%0d required=%0d", e[i].name, col_log[e[i].k], e[i].col); end
            checks++; if (row_log[e[i].k] !== e[i].row) begin failures++; $display("FAIL %s row got=%0d required=%0d", e[i].name, row_log[e[i].k], e[i].row); end
        end
    endtask

    task automatic test_clken_gap();
        logic [71:0] w_c2;
        int s0, s1, s2, g0, c3, last;
        frame_start();
        send_line(0, HD, s0);
        send_line(1, HD, s1);
        s2 = cyc;
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 8'(8'h20 + i));
        g0 = cyc;
        tick(0, 1, 0, 8'hAA);
        tick(0, 1, 0, 8'hAB);
        c3 = cyc;
        for (int i = 3; i < HD; i++) tick(0, 1, 1, 8'(8'h20 + i));
        tick(0, 0, 1, 8'h55);
        tick(0, 0, 0, 8'h00);
        last = cyc;
        for (int k = s2 - 1; k < last - 1; k++) begin
            checks++;
            if (sbo_log[k + 1] !== side_log[k]) begin
                failures++;
                $display("FAIL gap_sideband_t%0d {vsync,href,clken} got=%b required=%b", k - s2, sbo_log[k + 1], side_log[k]);
            end
        end
        w_c2 = win9(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22);
        for (int k = g0; k < g0 + 2; k++) begin
            checks++;
            if (win_log[k + 1] !== w_c2) begin failures++; $display("FAIL gap_frozen_window got=%h required=%h", win_log[k + 1], w_c2); end
            checks++;
            if (valid_log[k + 1] !== 1'b0) begin failures++; $display("FAIL gap_valid got=%b required=0", valid_log[k + 1]); end
        end
        checks++;
        if (win_log[c3 + 1] !== win9(8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23)) begin
            failures++;
            $display("FAIL gap_c3_window got=%h required=%h", win_log[c3 + 1],
                     win9(8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23));
        end
        checks++;
        if ({valid_log[c3 + 1], col_log[c3 + 1], row_log[c3 + 1]} !== {1'b1, CW'(3), CW'(2)}) begin
            failures++;
            $display("FAIL gap_c3_coords valid/col/row got=%b/%0d/%0d required=1/3/2", valid_log[c3 + 1], col_log[c3 + 1], row_log[c3 + 1]);
        end
    endtask

    task automatic test_overlong();
        exp_t e[$];
        int s0, s1, s2, s3;
        frame_start();
        send_line(0, HD, s0);
        send_line(1, HD, s1);
        send_line(2, HD + 2, s2);
        send_line(3, HD, s3);
        e.push_back(mk(s2 + 8, "long_r2c7", win9(8'h05, 8'h06, 8'h07, 8'h15, 8'h16, 8'h17, 8'h25, 8'h26, 8'h27), 1, 1, 7, 2));
        e.push_back(mk(s2 + 9, "long_px8", 72'h0, 0, 0, 7, 2));
        e.push_back(mk(s2 + 10, "long_px9", 72'h0, 0, 0, 7, 2));
        e.push_back(mk(s3 + 3, "long_next_c2", win9(8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32), 1, 1, 2, 3));
        e.push_back(mk(s3 + 8, "long_next_c7", win9(8'h15, 8'h16, 8'h17, 8'h25, 8'h26, 8'h27, 8'h35, 8'h36, 8'h37), 1, 1, 7, 3));
        foreach (e[i]) begin
            if (e[i].chk_win) begin
                checks++;
                if (win_log[e[i].k] !== e[i].win) begin failures++; $display("FAIL %s window got=%h required=%h", e[i].name, win_log[e[i].k], e[i].win); end
            end
            checks++; if (valid_log[e[i].k] !== e[i].valid) begin failures++; $display("FAIL %s valid got=%b required=%b", e[i].name, valid_log[e[i].k], e[i].valid); end
            checks++; if (col_log[e[i].k] !== e[i].col) begin failures++; $display("FAIL %s col got=%0d required=%0d", e[i].name, col_log[e[i].k], e[i].col); end
            checks++; if (row_log[e[i].k] !== e[i].row) begin failures++; $display("FAIL %s row got=%0d required=%0d", e[i].name, row_log[e[i].k], e[i].row); end
        end
    endtask

    task automatic test_vsync_href();
        int s;
        s = cyc;
        for (int i = 0; i < 4; i++) tick(1, 1, 1, 8'(8'h40 + i));
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if ({col_log[s + 1], row_log[s + 1], valid_log[s + 1]} !== {CW'(0), CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL vs_href_c0 col/row/valid got=%0d/%0d/%b required=0/0/0", col_log[s + 1], row_log[s + 1], valid_log[s + 1]);
        end
        checks++;
        if ({col_log[s + 4], row_log[s + 4], valid_log[s + 4], win_log[s + 4][7:0]} !== {CW'(3), CW'(0), 1'b0, 8'h43}) begin
            failures++;
            $display("FAIL vs_href_c3 col/row/valid/p33 got=%0d/%0d/%b/%h required=3/0/0/43",
                     col_log[s + 4], row_log[s + 4], valid_log[s + 4], win_log[s + 4][7:0]);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e[$];
        int s0, s1, sa, sb, sc;
        frame_start();
        send_line(0, HD, s0);
        send_line(1, HD, s1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 8'(8'h20 + i));
        checks++;
        if (win_log[cyc - 1][7:0] !== 8'h22) begin
            failures++;
            $display("FAIL pre_reset_p33 got=%h required=22", win_log[cyc - 1][7:0]);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({m_vs, m_hr, m_ce, m_valid, m_col, m_row, p11, p12, p13, p21, p22, p23, p31, p32, p33} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h required=0",
                     {m_vs, m_hr, m_ce, m_valid, m_col, m_row, p11, p12, p13, p21, p22, p23, p31, p32, p33});
        end
        hr = 1'b0; ce = 1'b0; din = '0;
        @(negedge clk);
        rstn = 1'b1;
        tick(0, 0, 0, 0);
        send_line(0, HD, sa);
        send_line(1, HD, sb);
        send_line(2, HD, sc);
        e.push_back(mk(sa + 4, "rst_lineA_c3", 72'h0, 0, 0, 3, 0));
        e.push_back(mk(sb + 5, "rst_lineB_c4", 72'h0, 0, 0, 4, 1));
        e.push_back(mk(sc + 3, "rst_lineC_c2", win9(8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22), 1, 1, 2, 2));
        foreach (e[i]) begin
            if (e[i].chk_win) begin
                checks++;
                if (win_log[e[i].k] !== e[i].win) begin failures++; $display("FAIL %s window got=%h required=%h", e[i].name, win_log[e[i].k], e[i].win); end
            end
            checks++; if (valid_log[e[i].k] !== e[i].valid) begin failures++; $display("FAIL %s valid got=%b required=%b", e[i].name, valid_log[e[i].k], e[i].valid); end
            checks++; if (col_log[e[i].k] !== e[i].col) begin failures++; $display("FAIL %s col got=%0d required=%0d", e[i].name, col_log[e[i].k], e[i].col); end
            checks++; if (row_log[e[i].k] !== e[i].row) begin failures++; $display("FAIL %s row got=%0d required=%0d", e[i].name, row_log[e[i].k], e[i].row); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_clken_gap();
        test_overlong();
        test_vsync_href();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
